// File: rtl/vfx_pkg.sv
// Shared definitions for the video-effects pipeline: frame geometry, address and pixel
// types, blur kernel codes and the streamer FSM encoding.
package vfx_pkg;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_LENGTH = 240;
    localparam int ADDR_W     = 17;
    localparam int PIXEL_W    = 12;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    // Codes outside this set are passed through to the filter unchanged.
    typedef enum logic [2:0] {
        KERNEL_1X1 = 3'b000,
        KERNEL_3X3 = 3'b001,
        KERNEL_5X5 = 3'b010
    } kernel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry skid buffer between the frame-buffer read port and the pixel output register.
module pixel_skid_buffer
    import vfx_pkg::*;
#(
    parameter int DATA_W = PIXEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_ready
);

    // valid/ready: a word moves across a side on a rising edge where valid && ready are
    // both high; when empty, an arriving word is presented downstream in the same cycle.
    logic [DATA_W-1:0] slot [2];
    logic              head;
    logic [1:0]        count;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              tail;

    assign up_ready = (count != 2'd2);
    assign dn_valid = (count != 2'd0) || up_valid;
    assign dn_data  = (count != 2'd0) ? slot[head] : up_data;
    assign bypass   = (count == 2'd0) && dn_ready;
    assign push     = up_valid && up_ready && !bypass;
    assign pop      = dn_ready && (count != 2'd0);
    assign tail     = head ^ (count == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            head    <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[tail] <= up_data;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads one frame from the frame buffer in raster order and streams it to the blur filter
// with sof/eol/eof markers, holding in-flight reads in a skid buffer while paused.
module frame_pixel_streamer #(
    parameter int IMG_WIDTH  = vfx_pkg::IMG_WIDTH,
    parameter int IMG_LENGTH = vfx_pkg::IMG_LENGTH,
    parameter int DATA_W     = $bits(vfx_pkg::pixel_t)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic [2:0]                 kernel_sel,
    output logic                       rd_en,
    output logic [vfx_pkg::ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]          rd_data,
    output logic                       ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [2:0]                 freq_flag,
    output logic                       sof,
    output logic                       eol,
    output logic                       eof,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_LENGTH - 1);

    vfx_pkg::stream_state_t     state;
    vfx_pkg::kernel_t           kernel_q;
    logic [vfx_pkg::ADDR_W-1:0] addr_q;
    logic [XW-1:0]              rd_x;
    logic [YW-1:0]              rd_y;
    logic [XW-1:0]              out_x;
    logic [YW-1:0]              out_y;
    logic                       rd_pending;
    logic                       rd_last;
    logic                       skid_ready;
    logic                       skid_valid;
    logic [DATA_W-1:0]          skid_data;
    logic                       emit;

    // Pause must suppress the read strobe in the same cycle, so rd_en is gated combinationally.
    assign rd_en     = (state == vfx_pkg::ST_FETCH) && !pause && skid_ready;
    assign rd_addr   = addr_q;
    assign rd_last   = (rd_x == X_LAST) && (rd_y == Y_LAST);
    assign busy      = (state != vfx_pkg::ST_IDLE);
    assign freq_flag = kernel_q;
    assign emit      = skid_valid && !pause;

    pixel_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (rd_pending),
        .up_data  (rd_data),
        .up_ready (skid_ready),
        .dn_valid (skid_valid),
        .dn_data  (skid_data),
        .dn_ready (!pause)
    );

    // Read side: FSM, raster address counters and the one-cycle read-latency tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= vfx_pkg::ST_IDLE;
            kernel_q   <= vfx_pkg::KERNEL_1X1;
            addr_q     <= '0;
            rd_x       <= '0;
            rd_y       <= '0;
            rd_pending <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            done       <= 1'b0;
            case (state)
                vfx_pkg::ST_IDLE: begin
                    if (start) begin
                        state    <= vfx_pkg::ST_FETCH;
                        kernel_q <= vfx_pkg::kernel_t'(kernel_sel);
                        addr_q   <= '0;
                        rd_x     <= '0;
                        rd_y     <= '0;
                    end
                end
                vfx_pkg::ST_FETCH: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            state <= vfx_pkg::ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + vfx_pkg::ADDR_W'(1);
                            if (rd_x == X_LAST) begin
                                rd_x <= '0;
                                rd_y <= rd_y + YW'(1);
                            end else begin
                                rd_x <= rd_x + XW'(1);
                            end
                        end
                    end
                end
                vfx_pkg::ST_DRAIN: begin
                    // Staying in DRAIN through the done cycle keeps a coincident start from
                    // being taken as a new frame request.
                    if (done) begin
                        state <= vfx_pkg::ST_IDLE;
                    end else if (eof) begin
                        done <= 1'b1;
                    end
                end
                default: state <= vfx_pkg::ST_IDLE;
            endcase
        end
    end

    // Output side: registered pixel and markers; data_out keeps its value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_out <= 1'b0;
            data_out  <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            ready_out <= emit;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            if ((state == vfx_pkg::ST_IDLE) && start) begin
                out_x <= '0;
                out_y <= '0;
            end else if (emit) begin
                data_out <= skid_data;
                sof      <= (out_x == '0) && (out_y == '0);
                eol      <= (out_x == X_LAST);
                eof      <= (out_x == X_LAST) && (out_y == Y_LAST);
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= (out_y == Y_LAST) ? '0 : out_y + YW'(1);
                end else begin
                    out_x <= out_x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Self-checking bench for frame_pixel_streamer on a reduced 64x72 frame so every scenario
// runs a complete frame; the frame-buffer model returns address & 12'hFFF.
module tb_frame_pixel_streamer;

    localparam int W  = 64;
    localparam int L  = 72;
    localparam int N  = W * L;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [2:0]    kernel_sel = 3'b000;
    logic          rd_en;
    logic [16:0]   rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic [2:0]    freq_flag;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [16:0]   exp_q[$];
    logic [2:0]    exp_flag = 3'b000;
    logic [DW-1:0] last_px = '0;
    int            next_rd = 0;
    int            pix_cnt = 0;
    int            rd_cnt = 0;
    int            sof_cnt = 0;
    int            eol_cnt = 0;
    int            eof_cnt = 0;
    bit            pause_prev = 1'b0;
    bit            eof_prev = 1'b0;
    bit            rand_pause = 1'b0;

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    frame_pixel_streamer #(
        .IMG_WIDTH  (W),
        .IMG_LENGTH (L),
        .DATA_W     (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .kernel_sel (kernel_sel),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .freq_flag  (freq_flag),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .busy       (busy),
        .done       (done)
    );

    // Frame buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(rd_addr & 17'h00FFF);
    end

    always @(posedge clk) begin
        #1;
        if (rand_pause) pause = ($urandom_range(0, 99) < 30);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_flag = 3'b000;
        last_px  = '0;
        next_rd  = 0;
        pix_cnt  = 0;
        rd_cnt   = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
        eof_prev = 1'b0;
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [16:0] idx;
        int          i;
        if (rst_n) begin
            if (pause_prev) check("ready_after_pause", ready_out, 0);
            if (pause) check("rd_en_during_pause", rd_en, 0);
            if (rd_en) begin
                check("rd_addr", rd_addr, next_rd);
                check("rd_in_frame", (next_rd < N), 1);
                next_rd++;
                rd_cnt++;
            end
            check("freq_flag", freq_flag, exp_flag);
            check("done_after_eof", done, eof_prev);
            if (ready_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    idx = exp_q.pop_front();
                    i   = int'(idx);
                    last_px = DW'(idx & 17'h00FFF);
                    check("data_out", data_out, last_px);
                    check("sof", sof, (i == 0));
                    check("eol", eol, ((i % W) == W - 1));
                    check("eof", eof, (i == N - 1));
                end
                pix_cnt++;
                if (sof) sof_cnt++;
                if (eol) eol_cnt++;
                if (eof) eof_cnt++;
            end else begin
                check("data_hold", data_out, last_px);
            end
            check("outstanding_reads", ((rd_cnt - pix_cnt) <= 2), 1);
            eof_prev = ready_out && eof;
        end
        pause_prev = pause;
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [2:0] k, input bit release_rst);
        @(posedge clk);
        #1;
        if (release_rst) rst_n = 1'b1;
        start      = 1'b1;
        kernel_sel = k;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_flag = k;
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back(17'(a));
        next_rd = 0;
        pix_cnt = 0;
        rd_cnt  = 0;
        sof_cnt = 0;
        eol_cnt = 0;
        eof_cnt = 0;
    endtask

    task automatic wait_done(input bit poke_start);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4 * N) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (poke_start) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("start_at_done_busy", busy, 0);
            check("start_at_done_rd_en", rd_en, 0);
            @(posedge clk);
            #1;
            check("start_at_done_rd_en2", rd_en, 0);
        end
        check("pixels_left", exp_q.size(), 0);
        check("pixel_count", pix_cnt, N);
        check("read_count", rd_cnt, N);
        check("sof_count", sof_cnt, 1);
        check("eol_count", eol_cnt, L);
        check("eof_count", eof_cnt, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c;
        clear_model();
        #2;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_ready", ready_out, 0);
        check("rst_data", data_out, 0);
        check("rst_freq", freq_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);

        // Start on the first edge after reset release; pin T1/T3 timing.
        start_frame(3'b001, 1'b1);
        check("t1_rd_en", rd_en, 1);
        check("t1_rd_addr", rd_addr, 0);
        check("t1_busy", busy, 1);
        check("t1_freq", freq_flag, 3'b001);
        @(posedge clk);
        #1;
        check("t2_ready", ready_out, 0);
        @(posedge clk);
        #1;
        check("t3_ready", ready_out, 1);
        check("t3_data", data_out, 12'h000);
        check("t3_sof", sof, 1);
        wait_done(1'b0);
        check("last_data", data_out, 12'h1FF);

        // Random ~30% pause across a full frame.
        rand_pause = 1'b1;
        start_frame(3'b000, 1'b0);
        wait_done(1'b0);
        rand_pause = 1'b0;
        @(posedge clk);
        #2;
        pause = 1'b0;

        // Kernel change and start pulses mid-frame; start coinciding with done.
        start_frame(3'b010, 1'b0);
        repeat (500) @(posedge clk);
        #1;
        kernel_sel = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mid_busy", busy, 1);
        repeat (300) @(posedge clk);
        #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1);
        check("freq_after_frame", freq_flag, 3'b010);
        start_frame(3'b001, 1'b0);
        check("freq_next_frame", freq_flag, 3'b001);
        wait_done(1'b0);

        // Asynchronous reset mid-frame, then restart on release.
        start_frame(3'b011, 1'b0);
        c = 0;
        while (pix_cnt < 2500 && c < 4 * N) begin
            @(posedge clk);
            c++;
        end
        check("reached_mid_frame", (pix_cnt >= 2500), 1);
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("arst_rd_en", rd_en, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_ready", ready_out, 0);
        check("arst_data", data_out, 0);
        check("arst_freq", freq_flag, 0);
        check("arst_markers", {sof, eol, eof}, 3'b000);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        repeat (2) @(posedge clk);
        start_frame(3'b101, 1'b1);
        check("rst_restart_rd_en", rd_en, 1);
        check("rst_restart_addr", rd_addr, 0);
        check("rst_restart_freq", freq_flag, 3'b101);
        wait_done(1'b0);

        // Pause held from T0: nothing streams, then a normal frame after release.
        pause = 1'b1;
        start_frame(3'b000, 1'b0);
        repeat (20) @(negedge clk);
        check("held_reads", (rd_cnt <= 2), 1);
        check("held_pixels", pix_cnt, 0);
        check("held_busy", busy, 1);
        @(posedge clk);
        #1;
        pause = 1'b0;
        wait_done(1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d failures so far, expected completion", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_pixel_streamer.md
FRAME_PIXEL_STREAMER -- requirements
Module: frame_pixel_streamer

Interface
REQ-001 SHALL have parameters: IMG_WIDTH, default 320, pixels per line; IMG_LENGTH, default 240, lines per frame; DATA_W, default 12, RGB444 pixel width.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request, sampled only in IDLE.
- pause  in  1  downstream hold request.
- kernel_sel  in  3  blur kernel code, captured at frame start.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  17  frame-buffer word address, y*IMG_WIDTH+x.
- rd_data  in  DATA_W  frame-buffer data, valid the cycle after rd_en/rd_addr are sampled.
- ready_out  out  1  data_out valid, drives filter ready_in.
- data_out  out  DATA_W  pixel.
- freq_flag  out  3  kernel code for the filter, constant for the whole frame.
- sof, eol, eof  out  1 each  qualified by ready_out: first pixel, last pixel of line, last pixel of frame.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at frame completion.

Function
REQ-003 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-004 IDLE with start=1 at cycle T0 SHALL latch kernel_sel into freq_flag, enter FETCH, and drive rd_en=1, rd_addr=0 in T1.
REQ-005 Without pause, the first pixel SHALL appear with ready_out=1 in T3, followed by one pixel per cycle for IMG_WIDTH*IMG_LENGTH consecutive cycles.
REQ-006 Pixels SHALL be emitted in raster order (x fastest), each exactly once, data_out equal to rd_data of the matching address.
REQ-007 The address counter SHALL wrap x at IMG_WIDTH-1 to 0 and increment y; FETCH SHALL end after issuing address IMG_WIDTH*IMG_LENGTH-1; no read beyond it.
REQ-008 DRAIN SHALL emit in-flight pixels, then pulse done for one cycle the cycle after eof, then return to IDLE.
REQ-009 sof SHALL be high only with pixel (0,0); eol with x=IMG_WIDTH-1; eof with (IMG_WIDTH-1, IMG_LENGTH-1); eof SHALL coincide with eol.
REQ-010 pause=1 in cycle k SHALL force ready_out=0 in cycle k+1 and rd_en=0 in cycle k; read data already in flight SHALL be held in a 2-entry skid buffer, never dropped.
REQ-011 After pause falls, streaming SHALL resume within 2 cycles, held pixels first, with order preserved.
REQ-012 start outside IDLE SHALL be ignored; kernel_sel changes mid-frame SHALL NOT alter freq_flag.
REQ-013 start and the final done pulse in the same cycle SHALL NOT start a frame; start SHALL be accepted only while the FSM is in IDLE.
REQ-014 data_out SHALL hold its last value while ready_out=0.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, with counters, skid buffer, and all outputs set to 0 (freq_flag=3'b000, rd_addr=0), including mid-frame.
REQ-016 Reset release SHALL take effect synchronously; the first start is accepted on the first clk edge after release.

Structure
REQ-017 IMG_WIDTH, IMG_LENGTH, ADDR_W (17), the pixel_t (12-bit) typedef, and the kernel-code enum (000=1x1, 001=3x3, 010=5x5) SHALL live in the shared vfx_pkg package.
REQ-018 The skid buffer SHALL be a sub-module pixel_skid_buffer (2-deep, valid/ready); FSM and counters SHALL be in the top module.

Verification
REQ-019 Frame-buffer model with mem[a]=a&12'hFFF, start at T0, no pause -> first ready_out in T3 with data 000; 76800 contiguous pixels, last data 12'hBFF; done one cycle after eof.
REQ-020 Random pause pattern (about 30 percent duty) across the full frame -> output sequence identical to REQ-019, exactly 76800 ready_out cycles, ready_out=0 in every cycle following pause=1.
REQ-021 Check markers -> sof count 1, eol count 240 at x=319, eof count 1 together with the last eol.
REQ-022 kernel_sel=3'b010 at start, then 3'b001 mid-frame, plus start pulses mid-frame -> freq_flag stays 010 and no restart occurs; the next frame latches the new code.
REQ-023 rst_n low at pixel 40000 -> all outputs 0 immediately (asynchronously); after release, a new start produces a full frame from address 0.
REQ-024 pause held continuously from T0 -> no ready_out and at most 2 outstanding reads; release -> normal frame, first data 000.
